// File: rtl/rob_dispatch_pkg.sv
// Shared widths, type/state encodings and the decode-buffer entry layout for rob_dispatch.
// Mirrors the codebase globals so the dispatcher and its scoreboard agree on field sizes.
package rob_dispatch_pkg;

    localparam int DEST_ADDR_SIZE    = 5;
    localparam int INS_TYPE_SIZE     = 2;
    localparam int ROB_ID_SIZE       = 4;
    localparam int EXCEPTION_ID_SIZE = 4;
    localparam int INS_STATE_SIZE    = 1;
    localparam int REG_ADDR_SIZE     = 5;
    localparam int PRED_ADDR_SIZE    = 3;

    localparam logic [INS_TYPE_SIZE-1:0] INS_TYPE_NONE = 2'b00;
    localparam logic [INS_TYPE_SIZE-1:0] INS_TYPE_ST   = 2'b01;
    localparam logic [INS_TYPE_SIZE-1:0] INS_TYPE_REG  = 2'b10;
    localparam logic [INS_TYPE_SIZE-1:0] INS_TYPE_PRED = 2'b11;

    localparam logic [INS_STATE_SIZE-1:0] INS_STATE_PENDING  = 1'b0;
    localparam logic [INS_STATE_SIZE-1:0] INS_STATE_FINISHED = 1'b1;

    typedef struct packed {
        logic [DEST_ADDR_SIZE-1:0]    dest;
        logic [INS_TYPE_SIZE-1:0]     ins_type;
        logic [EXCEPTION_ID_SIZE-1:0] exception;
        logic [REG_ADDR_SIZE-1:0]     src_a;
        logic                         src_a_en;
        logic [REG_ADDR_SIZE-1:0]     src_b;
        logic                         src_b_en;
        logic [PRED_ADDR_SIZE-1:0]    src_pred;
        logic                         src_pred_en;
    } dec_entry_t;

    // Faulting or no-op instructions retire straight into the ROB without visiting EX.
    function automatic logic needs_ex(input logic [INS_TYPE_SIZE-1:0] ins_type,
                                      input logic [EXCEPTION_ID_SIZE-1:0] exception);
        return (ins_type != INS_TYPE_NONE) && (exception == '0);
    endfunction

endpackage

// File: rtl/rob_dispatch_scoreboard.sv
// Register/predicate busy tracking with a 3-source + 1-destination hazard check.
// ROB_DISPATCH_WB_BYPASS_EN lets this cycle's writeback clear hide a hazard immediately.
module dispatch_scoreboard
    import rob_dispatch_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      set_reg_en,
    input  logic [REG_ADDR_SIZE-1:0]  set_reg_addr,
    input  logic                      set_pred_en,
    input  logic [PRED_ADDR_SIZE-1:0] set_pred_addr,
    input  logic                      clr_reg_en,
    input  logic [REG_ADDR_SIZE-1:0]  clr_reg_addr,
    input  logic                      clr_pred_en,
    input  logic [PRED_ADDR_SIZE-1:0] clr_pred_addr,
    input  logic [REG_ADDR_SIZE-1:0]  src_a,
    input  logic                      src_a_en,
    input  logic [REG_ADDR_SIZE-1:0]  src_b,
    input  logic                      src_b_en,
    input  logic [PRED_ADDR_SIZE-1:0] src_pred,
    input  logic                      src_pred_en,
    input  logic [REG_ADDR_SIZE-1:0]  dest_reg,
    input  logic                      dest_reg_en,
    input  logic [PRED_ADDR_SIZE-1:0] dest_pred,
    input  logic                      dest_pred_en,
    output logic                      hazard
);

    localparam int NUM_REG  = 1 << REG_ADDR_SIZE;
    localparam int NUM_PRED = 1 << PRED_ADDR_SIZE;

    logic [NUM_REG-1:0]  reg_busy;
    logic [NUM_REG-1:0]  reg_set_mask;
    logic [NUM_REG-1:0]  reg_clr_mask;
    logic [NUM_REG-1:0]  reg_view;
    logic [NUM_PRED-1:0] pred_busy;
    logic [NUM_PRED-1:0] pred_set_mask;
    logic [NUM_PRED-1:0] pred_clr_mask;
    logic [NUM_PRED-1:0] pred_view;

    always_comb begin
        reg_set_mask  = '0;
        reg_clr_mask  = '0;
        pred_set_mask = '0;
        pred_clr_mask = '0;
        if (set_reg_en)  reg_set_mask[set_reg_addr]   = 1'b1;
        if (clr_reg_en)  reg_clr_mask[clr_reg_addr]   = 1'b1;
        if (set_pred_en) pred_set_mask[set_pred_addr] = 1'b1;
        if (clr_pred_en) pred_clr_mask[clr_pred_addr] = 1'b1;
    end

`ifdef ROB_DISPATCH_WB_BYPASS_EN
    assign reg_view  = reg_busy & ~reg_clr_mask;
    assign pred_view = pred_busy & ~pred_clr_mask;
`else
    assign reg_view  = reg_busy;
    assign pred_view = pred_busy;
`endif

    assign hazard = (src_a_en     & reg_view[src_a])
                  | (src_b_en     & reg_view[src_b])
                  | (src_pred_en  & pred_view[src_pred])
                  | (dest_reg_en  & reg_view[dest_reg])
                  | (dest_pred_en & pred_view[dest_pred]);

    // Set is OR-ed after the clear so a same-cycle allocation keeps the bit busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_busy  <= '0;
            pred_busy <= '0;
        end else begin
            reg_busy  <= (reg_busy & ~reg_clr_mask) | reg_set_mask;
            pred_busy <= (pred_busy & ~pred_clr_mask) | pred_set_mask;
        end
    end

endmodule

// File: rtl/rob_dispatch.sv
// ID-stage dispatcher: decode skid FIFO, in-order ROB allocation, hazard stall, EX register.
// Optional ROB_DISPATCH_WB_BYPASS_EN (inside dispatch_scoreboard) fires dependents on the writeback cycle.
module rob_dispatch
    import rob_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dec_valid,
    output logic                         dec_ready,
    input  logic [DEST_ADDR_SIZE-1:0]    dec_dest_addr,
    input  logic [INS_TYPE_SIZE-1:0]     dec_ins_type,
    input  logic [EXCEPTION_ID_SIZE-1:0] dec_exception,
    input  logic [REG_ADDR_SIZE-1:0]     dec_src_a,
    input  logic [REG_ADDR_SIZE-1:0]     dec_src_b,
    input  logic                         dec_src_a_en,
    input  logic                         dec_src_b_en,
    input  logic [PRED_ADDR_SIZE-1:0]    dec_src_pred,
    input  logic                         dec_src_pred_en,
    output logic                         add_rob_entry,
    output logic [DEST_ADDR_SIZE-1:0]    entry_dest_addr,
    output logic [INS_TYPE_SIZE-1:0]     entry_ins_type,
    output logic [EXCEPTION_ID_SIZE-1:0] entry_exception,
    output logic [INS_STATE_SIZE-1:0]    entry_ins_state,
    input  logic                         rob_full,
    input  logic [ROB_ID_SIZE-1:0]       add_entry_id,
    input  logic                         halt,
    input  logic                         wr_reg_en,
    input  logic [REG_ADDR_SIZE-1:0]     wr_reg_addr,
    input  logic                         wr_pred_en,
    input  logic [PRED_ADDR_SIZE-1:0]    wr_pred_addr,
    output logic                         ex_valid,
    input  logic                         ex_ready,
    output logic [ROB_ID_SIZE-1:0]       ex_rob_id,
    output logic [DEST_ADDR_SIZE-1:0]    ex_dest_addr,
    output logic [INS_TYPE_SIZE-1:0]     ex_ins_type
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    dec_entry_t     fifo_mem [FIFO_DEPTH];
    dec_entry_t     dec_in_p0;
    dec_entry_t     head_p0;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           halted;
    logic           push;
    logic           fire_p0;
    logic           needs_ex_p0;
    logic           hazard_p0;
    logic           ex_free;

    // Stage p0: decode capture and FIFO head evaluation
    assign dec_in_p0 = '{dest:        dec_dest_addr,
                         ins_type:    dec_ins_type,
                         exception:   dec_exception,
                         src_a:       dec_src_a,
                         src_a_en:    dec_src_a_en,
                         src_b:       dec_src_b,
                         src_b_en:    dec_src_b_en,
                         src_pred:    dec_src_pred,
                         src_pred_en: dec_src_pred_en};

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == PW'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign dec_ready  = ~fifo_full & ~halted;
    assign push       = dec_valid & dec_ready;
    assign head_p0    = fifo_mem[rd_ptr[AW-1:0]];

    assign needs_ex_p0 = needs_ex(head_p0.ins_type, head_p0.exception);
    assign ex_free     = ~ex_valid | ex_ready;
    assign fire_p0     = ~fifo_empty & ~rob_full & ~halted & ~hazard_p0
                       & (~needs_ex_p0 | ex_free);

    assign add_rob_entry   = fire_p0;
    assign entry_dest_addr = head_p0.dest;
    assign entry_ins_type  = head_p0.ins_type;
    assign entry_exception = head_p0.exception;
    assign entry_ins_state = needs_ex_p0 ? INS_STATE_PENDING : INS_STATE_FINISHED;

    dispatch_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .set_reg_en    (fire_p0 & (head_p0.ins_type == INS_TYPE_REG)),
        .set_reg_addr  (head_p0.dest[REG_ADDR_SIZE-1:0]),
        .set_pred_en   (fire_p0 & (head_p0.ins_type == INS_TYPE_PRED)),
        .set_pred_addr (head_p0.dest[PRED_ADDR_SIZE-1:0]),
        .clr_reg_en    (wr_reg_en),
        .clr_reg_addr  (wr_reg_addr),
        .clr_pred_en   (wr_pred_en),
        .clr_pred_addr (wr_pred_addr),
        .src_a         (head_p0.src_a),
        .src_a_en      (head_p0.src_a_en),
        .src_b         (head_p0.src_b),
        .src_b_en      (head_p0.src_b_en),
        .src_pred      (head_p0.src_pred),
        .src_pred_en   (head_p0.src_pred_en),
        .dest_reg      (head_p0.dest[REG_ADDR_SIZE-1:0]),
        .dest_reg_en   (head_p0.ins_type == INS_TYPE_REG),
        .dest_pred     (head_p0.dest[PRED_ADDR_SIZE-1:0]),
        .dest_pred_en  (head_p0.ins_type == INS_TYPE_PRED),
        .hazard        (hazard_p0)
    );

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= dec_in_p0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            halted <= 1'b0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + PW'(1);
            if (fire_p0) rd_ptr <= rd_ptr + PW'(1);
            if (halt)    halted <= 1'b1;
        end
    end

    // Stage p1: EX output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_rob_id    <= '0;
            ex_dest_addr <= '0;
            ex_ins_type  <= '0;
        end else if (fire_p0 && needs_ex_p0) begin
            ex_valid     <= 1'b1;
            ex_rob_id    <= add_entry_id;
            ex_dest_addr <= head_p0.dest;
            ex_ins_type  <= head_p0.ins_type;
        end else if (ex_ready) begin
            ex_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rob_dispatch.sv
// Self-checking bench for rob_dispatch: directed scenarios then randomized traffic,
// each cycle compared against a queue-based reference model of the dispatch rules.
module tb_rob_dispatch;
    import rob_dispatch_pkg::*;

    localparam int DEPTH = 2;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         dec_valid;
    logic                         dec_ready;
    logic [DEST_ADDR_SIZE-1:0]    dec_dest_addr;
    logic [INS_TYPE_SIZE-1:0]     dec_ins_type;
    logic [EXCEPTION_ID_SIZE-1:0] dec_exception;
    logic [REG_ADDR_SIZE-1:0]     dec_src_a;
    logic [REG_ADDR_SIZE-1:0]     dec_src_b;
    logic                         dec_src_a_en;
    logic                         dec_src_b_en;
    logic [PRED_ADDR_SIZE-1:0]    dec_src_pred;
    logic                         dec_src_pred_en;
    logic                         add_rob_entry;
    logic [DEST_ADDR_SIZE-1:0]    entry_dest_addr;
    logic [INS_TYPE_SIZE-1:0]     entry_ins_type;
    logic [EXCEPTION_ID_SIZE-1:0] entry_exception;
    logic [INS_STATE_SIZE-1:0]    entry_ins_state;
    logic                         rob_full;
    logic [ROB_ID_SIZE-1:0]       add_entry_id;
    logic                         halt;
    logic                         wr_reg_en;
    logic [REG_ADDR_SIZE-1:0]     wr_reg_addr;
    logic                         wr_pred_en;
    logic [PRED_ADDR_SIZE-1:0]    wr_pred_addr;
    logic                         ex_valid;
    logic                         ex_ready;
    logic [ROB_ID_SIZE-1:0]       ex_rob_id;
    logic [DEST_ADDR_SIZE-1:0]    ex_dest_addr;
    logic [INS_TYPE_SIZE-1:0]     ex_ins_type;

    always #5 clk = ~clk;

    rob_dispatch #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_dest_addr(dec_dest_addr), .dec_ins_type(dec_ins_type),
        .dec_exception(dec_exception), .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
        .dec_src_a_en(dec_src_a_en), .dec_src_b_en(dec_src_b_en),
        .dec_src_pred(dec_src_pred), .dec_src_pred_en(dec_src_pred_en),
        .add_rob_entry(add_rob_entry), .entry_dest_addr(entry_dest_addr),
        .entry_ins_type(entry_ins_type), .entry_exception(entry_exception),
        .entry_ins_state(entry_ins_state), .rob_full(rob_full),
        .add_entry_id(add_entry_id), .halt(halt),
        .wr_reg_en(wr_reg_en), .wr_reg_addr(wr_reg_addr),
        .wr_pred_en(wr_pred_en), .wr_pred_addr(wr_pred_addr),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rob_id(ex_rob_id),
        .ex_dest_addr(ex_dest_addr), .ex_ins_type(ex_ins_type)
    );

    typedef struct {
        logic [4:0] dest;
        logic [1:0] t;
        logic [3:0] exc;
        logic [4:0] a;
        logic       aen;
        logic [4:0] b;
        logic       ben;
        logic [2:0] p;
        logic       pen;
    } ment_t;

    ment_t      mq[$];
    bit         m_reg_busy [32];
    bit         m_pred_busy [8];
    bit         m_halted;
    bit         m_exv;
    logic [3:0] m_ex_id;
    logic [4:0] m_ex_dest;
    logic [1:0] m_ex_type;

    int   errors = 0;
    int   checks = 0;
    logic last_fire;
    logic last_ready;
    logic [INS_STATE_SIZE-1:0] last_state;
    logic [INS_TYPE_SIZE-1:0]  last_type;
    logic [ROB_ID_SIZE-1:0]    held_id;
    logic [DEST_ADDR_SIZE-1:0] held_dest;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < 32; i++) m_reg_busy[i] = 1'b0;
        for (int i = 0; i < 8; i++)  m_pred_busy[i] = 1'b0;
        m_halted  = 1'b0;
        m_exv     = 1'b0;
        m_ex_id   = '0;
        m_ex_dest = '0;
        m_ex_type = '0;
    endtask

    function automatic bit m_hazard(input ment_t e);
        bit rb [32];
        bit pb [8];
        rb = m_reg_busy;
        pb = m_pred_busy;
`ifdef ROB_DISPATCH_WB_BYPASS_EN
        if (wr_reg_en)  rb[wr_reg_addr]  = 1'b0;
        if (wr_pred_en) pb[wr_pred_addr] = 1'b0;
`endif
        return (e.aen && rb[e.a]) || (e.ben && rb[e.b]) || (e.pen && pb[e.p]) ||
               (e.t == 2'b10 && rb[e.dest]) || (e.t == 2'b11 && pb[e.dest[2:0]]);
    endfunction

    task automatic idle();
        dec_valid = 0; dec_dest_addr = '0; dec_ins_type = '0; dec_exception = '0;
        dec_src_a = '0; dec_src_b = '0; dec_src_a_en = 0; dec_src_b_en = 0;
        dec_src_pred = '0; dec_src_pred_en = 0;
        rob_full = 0; add_entry_id = '0; halt = 0;
        wr_reg_en = 0; wr_reg_addr = '0; wr_pred_en = 0; wr_pred_addr = '0;
        ex_ready = 1;
    endtask

    task automatic dec(input logic [1:0] t, input logic [4:0] d, input logic [3:0] e,
                       input logic [4:0] a, input logic aen);
        dec_valid = 1; dec_ins_type = t; dec_dest_addr = d; dec_exception = e;
        dec_src_a = a; dec_src_a_en = aen; dec_src_b = '0; dec_src_b_en = 0;
        dec_src_pred = '0; dec_src_pred_en = 0;
    endtask

    // Called just after a posedge; leaves the bench just after the next posedge.
    task automatic cycle();
        bit    e_ready, e_fire, e_needs;
        ment_t h, n;
        @(negedge clk);
        #1;
        e_ready = (mq.size() < DEPTH) && !m_halted;
        e_fire  = 1'b0;
        e_needs = 1'b0;
        if (mq.size() > 0) begin
            h = mq[0];
            e_needs = (h.t != 2'b00) && (h.exc == 4'd0);
            e_fire  = !rob_full && !m_halted && !m_hazard(h) && (!e_needs || !m_exv || ex_ready);
        end
        chk("dec_ready", dec_ready, e_ready);
        chk("add_rob_entry", add_rob_entry, e_fire);
        if (e_fire) begin
            chk("entry_dest_addr", entry_dest_addr, h.dest);
            chk("entry_ins_type", entry_ins_type, h.t);
            chk("entry_exception", entry_exception, h.exc);
            chk("entry_ins_state", entry_ins_state, e_needs ? 0 : 1);
        end
        last_fire  = add_rob_entry;
        last_ready = dec_ready;
        last_state = entry_ins_state;
        last_type  = entry_ins_type;
        n = '{dec_dest_addr, dec_ins_type, dec_exception, dec_src_a, dec_src_a_en,
              dec_src_b, dec_src_b_en, dec_src_pred, dec_src_pred_en};
        @(posedge clk);
        if (e_fire) begin
            void'(mq.pop_front());
            if (e_needs) begin
                m_exv = 1'b1; m_ex_id = add_entry_id; m_ex_dest = h.dest; m_ex_type = h.t;
            end else if (ex_ready) m_exv = 1'b0;
        end else if (ex_ready) m_exv = 1'b0;
        if (wr_reg_en)  m_reg_busy[wr_reg_addr]   = 1'b0;
        if (wr_pred_en) m_pred_busy[wr_pred_addr] = 1'b0;
        if (e_fire && h.t == 2'b10) m_reg_busy[h.dest] = 1'b1;
        if (e_fire && h.t == 2'b11) m_pred_busy[h.dest[2:0]] = 1'b1;
        if (dec_valid && e_ready) mq.push_back(n);
        if (halt) m_halted = 1'b1;
        #1;
        chk("ex_valid", ex_valid, m_exv);
        chk("ex_rob_id", ex_rob_id, m_ex_id);
        chk("ex_dest_addr", ex_dest_addr, m_ex_dest);
        chk("ex_ins_type", ex_ins_type, m_ex_type);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases after a posedge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        idle();
        reset = 1'b0;
        #1;
        model_clear();
        chk("rst_dec_ready", dec_ready, 1);
        chk("rst_add_rob_entry", add_rob_entry, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_rob_id", ex_rob_id, 0);
        chk("rst_ex_dest", ex_dest_addr, 0);
        chk("rst_ex_type", ex_ins_type, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        model_clear();
        do_reset();

        // Single reg-write: allocation one cycle after acceptance, then EX.
        dec(2'b10, 5'd5, 4'd0, 5'd0, 0); add_entry_id = 4'd3;
        cycle();
        chk("t1_no_alloc_on_accept", last_fire, 0);
        dec_valid = 0;
        cycle();
        chk("t1_alloc", last_fire, 1);
        chk("t1_state_pending", last_state, 0);
        chk("t1_ex_valid", ex_valid, 1);
        chk("t1_ex_rob_id", ex_rob_id, 3);

        // RAW on r5 until writeback.
        dec(2'b01, 5'd0, 4'd0, 5'd5, 1);
        cycle();
        dec_valid = 0;
        cycle();
        chk("t2_raw_stall0", last_fire, 0);
        cycle();
        chk("t2_raw_stall1", last_fire, 0);
        wr_reg_en = 1; wr_reg_addr = 5'd5;
        cycle();
`ifdef ROB_DISPATCH_WB_BYPASS_EN
        chk("t2_wb_cycle", last_fire, 1);
`else
        chk("t2_wb_cycle", last_fire, 0);
`endif
        wr_reg_en = 0;
        cycle();
`ifdef ROB_DISPATCH_WB_BYPASS_EN
        chk("t2_after_wb", last_fire, 0);
`else
        chk("t2_after_wb", last_fire, 1);
`endif

        // rob_full: two accepts fill the FIFO, then back-to-back on release.
        rob_full = 1;
        dec(2'b10, 5'd6, 4'd0, 5'd0, 0); cycle(); chk("t3_acc0", last_ready, 1);
        dec(2'b10, 5'd7, 4'd0, 5'd0, 0); cycle(); chk("t3_acc1", last_ready, 1);
        dec(2'b10, 5'd8, 4'd0, 5'd0, 0); cycle(); chk("t3_full", last_ready, 0);
        chk("t3_no_alloc", last_fire, 0);
        cycle();
        rob_full = 0;
        cycle(); chk("t3_b2b0", last_fire, 1); chk("t3_full_pop_ready", last_ready, 0);
        cycle(); chk("t3_b2b1", last_fire, 1); chk("t3_accept3", last_ready, 1);
        dec_valid = 0;
        cycle(); chk("t3_b2b2", last_fire, 1);
        wr_reg_en = 1;
        wr_reg_addr = 5'd6; cycle();
        wr_reg_addr = 5'd7; cycle();
        wr_reg_addr = 5'd8; cycle();
        wr_reg_en = 0;

        // Faulting no-op retires as FINISHED and bypasses EX.
        dec(2'b00, 5'd9, 4'd4, 5'd0, 0); cycle();
        dec_valid = 0; cycle();
        chk("t4_alloc", last_fire, 1);
        chk("t4_state_finished", last_state, 1);
        chk("t4_no_ex", ex_valid, 0);

        // EX back-pressure: type-00 still allocates, EX-bound head waits, payload stable.
        dec(2'b10, 5'd10, 4'd0, 5'd0, 0); cycle();
        dec_valid = 0; add_entry_id = 4'd7; cycle();
        ex_ready = 0; add_entry_id = 4'd12;
        held_id = ex_rob_id; held_dest = ex_dest_addr;
        dec(2'b00, 5'd1, 4'd0, 5'd0, 0); cycle();
        dec(2'b10, 5'd11, 4'd0, 5'd0, 0); cycle();
        chk("t6_none_allocs", last_fire, 1);
        dec_valid = 0; cycle();
        chk("t6_ex_head_held", last_fire, 0);
        chk("t6_ex_id_stable", ex_rob_id, 7);
        chk("t6_ex_dest_stable", ex_dest_addr, 10);
        chk("t6_held_match", {ex_rob_id, ex_dest_addr}, {held_id, held_dest});
        ex_ready = 1; cycle();
        chk("t6_release", last_fire, 1);
        chk("t6_new_id", ex_rob_id, 12);
        wr_reg_en = 1;
        wr_reg_addr = 5'd10; cycle();
        wr_reg_addr = 5'd11; cycle();
        wr_reg_en = 0;

        // Halt in the same cycle as a fire: that fire lands, nothing after.
        dec(2'b10, 5'd12, 4'd0, 5'd0, 0); cycle();
        dec(2'b01, 5'd13, 4'd0, 5'd0, 0); halt = 1; cycle();
        chk("t5_fire_with_halt", last_fire, 1);
        dec_valid = 0; halt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5_halted_ready", last_ready, 0);
            chk("t5_halted_no_fire", last_fire, 0);
            chk("t5_fifo_retained", last_type, 1);
        end
        do_reset();

        // Reset while an instruction sits in EX.
        ex_ready = 0;
        dec(2'b11, 5'd2, 4'd0, 5'd0, 0); cycle();
        dec_valid = 0; cycle();
        chk("t7_ex_inflight", ex_valid, 1);
        do_reset();

        // Randomized traffic.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                dec_valid       = 1'($urandom % 2);
                dec_ins_type    = 2'($urandom % 4);
                dec_dest_addr   = 5'($urandom % 8);
                dec_exception   = ($urandom % 6 == 0) ? 4'($urandom) : 4'd0;
                dec_src_a       = 5'($urandom % 8);
                dec_src_a_en    = 1'($urandom % 2);
                dec_src_b       = 5'($urandom % 8);
                dec_src_b_en    = 1'($urandom % 2);
                dec_src_pred    = 3'($urandom % 8);
                dec_src_pred_en = 1'($urandom % 2);
                rob_full        = ($urandom % 4 == 0);
                add_entry_id    = 4'($urandom);
                halt            = ($urandom % 300 == 0);
                wr_reg_en       = 1'($urandom % 2);
                wr_reg_addr     = 5'($urandom % 8);
                wr_pred_en      = 1'($urandom % 2);
                wr_pred_addr    = 3'($urandom % 8);
                ex_ready        = ($urandom % 3 != 0);
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
